// File: rtl/snitch_regfile_wb_ctrl.sv
// Writeback controller for the Snitch integer register file: round-robin writeback arbitration
// onto the single write port, plus a per-register busy scoreboard for RAW/WAW hazard checks.
module snitch_regfile_wb_ctrl #(
   parameter int unsigned NrReq      = 3,
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned AddrWidth  = 5,
   parameter bit          ZeroRegZero = 1'b1,
   parameter int unsigned NrChkPorts = 2,
   localparam int unsigned NumWords  = 2**AddrWidth
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NrReq-1:0]                wb_valid_i,
   output logic [NrReq-1:0]                wb_ready_o,
   input  logic [NrReq*AddrWidth-1:0]      wb_addr_i,
   input  logic [NrReq*DataWidth-1:0]      wb_data_i,
   input  logic                            rsv_valid_i,
   input  logic [AddrWidth-1:0]            rsv_addr_i,
   output logic                            rsv_ready_o,
   input  logic [NrChkPorts*AddrWidth-1:0] chk_addr_i,
   output logic [NrChkPorts-1:0]           chk_busy_o,
   output logic [AddrWidth-1:0]            rf_waddr_o,
   output logic [DataWidth-1:0]            rf_wdata_o,
   output logic                            rf_we_o,
   output logic [NumWords-1:0]             busy_o
);

   localparam int unsigned PrioWidth = (NrReq > 1) ? $clog2(NrReq) : 1;

   logic [PrioWidth-1:0] prio_q, prio_d;
   logic [PrioWidth-1:0] gnt_idx;
   logic                 gnt_valid;
   logic                 hi_found;
   logic [AddrWidth-1:0] gnt_addr;
   logic [DataWidth-1:0] gnt_data;
   logic                 gnt_is_zero;
   logic                 rsv_is_zero;

   logic [NumWords-1:0]  busy_q, busy_d;
   logic                 rf_we_q, rf_we_d;
   logic [AddrWidth-1:0] rf_waddr_q, rf_waddr_d;
   logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;

   // Lowest valid index at or above the pointer wins; otherwise wrap to the lowest valid index.
   always_comb begin
      gnt_valid = 1'b0;
      hi_found  = 1'b0;
      gnt_idx   = '0;
      for (int i = 0; i < NrReq; i++) begin
         if (wb_valid_i[i] && (i >= int'(prio_q)) && !hi_found) begin
            hi_found = 1'b1;
            gnt_idx  = PrioWidth'(i);
         end
      end
      for (int i = 0; i < NrReq; i++) begin
         if (wb_valid_i[i] && !hi_found && !gnt_valid) begin
            gnt_idx = PrioWidth'(i);
         end
         if (wb_valid_i[i]) begin
            gnt_valid = 1'b1;
         end
      end
   end

   always_comb begin
      gnt_addr = '0;
      gnt_data = '0;
      for (int i = 0; i < NrReq; i++) begin
         wb_ready_o[i] = gnt_valid && !rst_i && (gnt_idx == PrioWidth'(i));
         if (gnt_idx == PrioWidth'(i)) begin
            gnt_addr = wb_addr_i[i*AddrWidth +: AddrWidth];
            gnt_data = wb_data_i[i*DataWidth +: DataWidth];
         end
      end
   end

   assign gnt_is_zero = ZeroRegZero && (gnt_addr == '0);
   assign rsv_is_zero = ZeroRegZero && (rsv_addr_i == '0);
   assign rsv_ready_o = !rst_i && (rsv_is_zero || !busy_q[rsv_addr_i]);

   always_comb begin
      prio_d     = prio_q;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      busy_d     = busy_q;
      if (gnt_valid) begin
         prio_d = (gnt_idx == PrioWidth'(NrReq - 1)) ? '0 : gnt_idx + PrioWidth'(1);
         busy_d[gnt_addr] = 1'b0;
         if (!gnt_is_zero) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = gnt_addr;
            rf_wdata_d = gnt_data;
         end
      end
      // Applied after the clear so a same-register set wins.
      if (rsv_valid_i && rsv_ready_o && !rsv_is_zero) begin
         busy_d[rsv_addr_i] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prio_q     <= '0;
         busy_q     <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         prio_q     <= prio_d;
         busy_q     <= busy_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   always_comb begin
      for (int k = 0; k < NrChkPorts; k++) begin
         chk_busy_o[k] = busy_q[chk_addr_i[k*AddrWidth +: AddrWidth]];
      end
   end

   assign busy_o     = busy_q;
   assign rf_we_o    = rf_we_q;
   assign rf_waddr_o = rf_waddr_q;
   assign rf_wdata_o = rf_wdata_q;

   wb_to_idle_reg: assert property (@(posedge clk_i) disable iff (rst_i)
      (gnt_valid && !gnt_is_zero) |-> busy_q[gnt_addr]);

endmodule

// File: doc/snitch_regfile_wb_ctrl.md
# snitch_regfile_wb_ctrl

Writeback controller for the Snitch integer register file. It arbitrates several writeback requesters (ALU, LSU, accelerator response) onto the single register-file write port using round-robin. It also keeps a per-register busy scoreboard so the issue stage can detect RAW/WAW hazards. It sits between the execution units and `snitch_regfile` and drives that block's `waddr_i`/`wdata_i`/`we_i` directly.

## Interface

- `NrReq`, 3: number of writeback requesters (≥1).
- `DataWidth`, 32: register width.
- `AddrWidth`, 5: register address width; `NumWords = 2**AddrWidth`.
- `ZeroRegZero`, 1: register 0 is hardwired zero; it is never written and never marked busy.
- `NrChkPorts`, 2: number of scoreboard query ports.

Ports:

- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high. One clock domain only.
- `wb_valid_i`  in  NrReq  requester has a writeback pending.
- `wb_ready_o`  out  NrReq  writeback accepted this cycle (one-hot or zero).
- `wb_addr_i`  in  NrReq×AddrWidth  destination register.
- `wb_data_i`  in  NrReq×DataWidth  write data.
- `rsv_valid_i`  in  1  issue stage requests a destination reservation.
- `rsv_addr_i`  in  AddrWidth  register to reserve.
- `rsv_ready_o`  out  1  reservation accepted.
- `chk_addr_i`  in  NrChkPorts×AddrWidth  operand/destination registers to check.
- `chk_busy_o`  out  NrChkPorts  the checked register has a pending write.
- `rf_waddr_o`  out  AddrWidth  register-file write address (registered).
- `rf_wdata_o`  out  DataWidth  register-file write data (registered).
- `rf_we_o`  out  1  register-file write enable (registered).
- `busy_o`  out  NumWords  full scoreboard vector.

## Operation

- **Arbitration.** Round-robin over the asserted `wb_valid_i` bits, starting at pointer `prio_q`.
  - The granted requester `g` gets `wb_ready_o[g]=1`, combinationally, in the same cycle.
  - After a grant, `prio_q <= (g+1) mod NrReq`. With no grant, `prio_q` holds.
- **No backpressure.** The register file has no backpressure, so the output stage drains every cycle. Whenever any valid is asserted, exactly one grant is issued.
- **Output stage.** On a grant, `rf_waddr_o`, `rf_wdata_o` and `rf_we_o` are registered from the granted request.
  - `rf_we_o=0` when there is no grant.
  - `rf_we_o=0` when `ZeroRegZero` is set and the granted address is 0. The request is still accepted and dropped.
  - `rf_waddr_o`/`rf_wdata_o` hold their last value when `rf_we_o=0`.
- **Scoreboard set.** `busy_q[a]` is set when `rsv_valid_i && rsv_ready_o` with `rsv_addr_i=a`.
- **Scoreboard clear.** `busy_q[a]` is cleared when a writeback to `a` is accepted, in the same edge that loads the output register.
- **Reservation acceptance.** `rsv_ready_o = !busy_q[rsv_addr_i]`, so a WAW stall holds the reservation off.
  - Register 0 under `ZeroRegZero` always gets `rsv_ready_o=1` and sets no bit.
  - `rsv_ready_o` does not depend on `rsv_valid_i`.
- **Simultaneous set and clear** of the same register in one cycle: the set wins and `busy_q` stays 1.
  - This cannot arise through `rsv_ready_o`, since the bit was already busy.
  - A clear still lands when the reservation targets a different register.
- **Query ports.** `chk_busy_o[k] = busy_q[chk_addr_i[k]]`, combinational from the registered state.
  - There is no forwarding of same-cycle clears: the issue stage sees a freed register one cycle after the write is accepted.
- **Writeback to a non-busy register.** The write is performed normally. The simulation assertion `wb_to_idle_reg` fires.

## Timing

- **Reset values.** All asserted immediately on `rst_i` (asynchronous) and held while `rst_i` is high:
  - `rf_we_o=0`, `rf_waddr_o=0`, `rf_wdata_o=0`.
  - `busy_q=0`, so `busy_o=0` and `chk_busy_o=0`.
  - `prio_q=0`.
- **Outputs during reset.** While `rst_i` is high, `wb_ready_o=0` and `rsv_ready_o=0`.
- **Write latency.** Acceptance in cycle N gives `rf_we_o=1` in cycle N+1. The regfile then captures the data, and it is readable from cycle N+2.
- **Scoreboard latency.** The busy bit drops at edge N→N+1, so `chk_busy_o` is low from cycle N+1.
- **Throughput.** One write per cycle, sustained.
- **Fairness.** A continuously asserted requester is granted within `NrReq` cycles.
- **Reset mid-operation.** Any write pending in the output register is discarded; `rf_we_o` is forced to 0 asynchronously. All reservations are lost.

## Test plan

- **Reset mid-stream.** Reserve x5, accept a write to x5, assert `rst_i` in cycle N+1. Expect `rf_we_o` to drop immediately, `busy_o=0` and `prio_q=0` after reset. The first post-reset grant goes to requester 0 when all requesters are valid.
- **Basic flow.** Reserve x5 (`rsv_ready_o=1`), then requester 1 writes x5 with 0xDEADBEEF. Expect:
  - `wb_ready_o=3'b010` in cycle N.
  - `rf_we_o=1`, `rf_waddr_o=5`, `rf_wdata_o=0xDEADBEEF` in cycle N+1.
  - `chk_busy_o` for x5 low from cycle N+1.
- **Round-robin.** All three requesters held valid with distinct addresses for 6 cycles. Expect grants 0,1,2,0,1,2 and one `rf_we_o` pulse per cycle.
- **WAW stall.** Reserve x7, then request x7 again. Expect `rsv_ready_o=0` until x7 is written back, and `rsv_ready_o=1` in the cycle after acceptance.
- **Zero register.**
  - Reserve x0: expect `rsv_ready_o=1` and `busy_o[0]` stays 0.
  - Writeback to x0 with data 0x1234: expect `wb_ready_o` asserted and `rf_we_o` stays 0.
- **Simultaneous set and clear.** Reserve x3 while a writeback to x9 (busy) is accepted in the same cycle. Expect `busy_o[3]=1` and `busy_o[9]=0` after the edge.
